log_bf16: RTL and testbench
===========================

// Module: log_bf16
// PURPOSE
// - Pipelined natural-log unit for bfloat16: data_o = ln(data_i), the inverse companion to the bf16 exp unit.
// - Sits on the same streaming datapath as exp; valid/ready in and out, 3-stage pipeline, sideband tag carried through.
// - ln(x) = (E-127)*ln2 + ln(1.m); ln(1.m) is piecewise-linear over 8 segments selected by m[6:4].
// PARAMETERS
// - TAG_W   4   width of the opaque tag carried alongside each operand
// PORTS
// - clk      in   1      clock, all logic on rising edge
// - rst      in   1      synchronous reset, active-high
// - valid_i  in   1      operand valid
// - ready_o  out  1      unit can accept operand this cycle
// - data_i   in   16     bf16 operand {s, e[7:0], m[6:0]}
// - tag_i    in   TAG_W  sideband tag
// - valid_o  out  1      result valid
// - ready_i  in   1      downstream accepts result
// - data_o   out  16     bf16 ln(data_i)
// - tag_o    out  TAG_W  tag of the operand that produced data_o
// BEHAVIOUR
// - Reset: valid_o=0, data_o=0, tag_o=0, all internal stage valids cleared; in-flight operands are dropped.
// - Global advance: adv = ~valid_o | ready_i; ready_o = adv. All 3 stages shift together on adv; bubbles are not collapsed.
// - Transfer in on valid_i & ready_o; transfer out on valid_o & ready_i. Latency exactly 3 cycles when never stalled; throughput 1/cycle.
// - While valid_o & ~ready_i: data_o, tag_o, valid_o held stable, no stage changes.
// - S1 classify + lookup. Special classes (bypass arithmetic, tagged through):
//   - e==255, m!=0 (NaN), or s==1 with nonzero magnitude (incl. -inf) -> 16'h7FC0
//   - e==0 (zero or denormal, either sign) -> 16'hFF80 (-inf)
//   - 16'h7F80 (+inf) -> 16'h7F80
// - Segment table T[k], k=0..8, Q0.14: 0,1930,3656,5218,6643,7955,9169,10299,11357.
// - S1: k=m[6:4], f=m[3:0]; frac = T[k] + (((T[k+1]-T[k]) * f) >> 4), unsigned 14-bit result.
// - S2: S = (e-127)*11357 + frac, signed 24-bit two's complement, Q9.14 (|S| < 2^21, no overflow).
// - S3 convert: S==0 -> 16'h0000. Else sign = S[23], A = |S|, p = index of leading one of A;
//   exponent = p - 14 + 127; mantissa = the 7 bits of A immediately below bit p (zero-filled if p<7).
// - Default rounding: truncation of bits below the 7-bit mantissa.
// - p range 0..20 -> exponent 113..133; never subnormal, never overflow.
// CONFIGURATION
// - LOG_ROUND_EN defined: S3 rounds to nearest-even on bits below the mantissa; mantissa carry-out increments exponent and clears mantissa.
// - LOG_ROUND_EN undefined: truncation as above. Latency and handshake identical in both builds.
// TESTING
// - data_i=16'h3F80 (1.0), tag 3 -> 3 cycles later data_o=16'h0000, tag_o=3.
// - data_i=16'h4000 (2.0) -> data_o=16'h3F31; data_i=16'h3F00 (0.5) -> data_o=16'hBF31 (both builds).
// - data_i=16'h402E (2.71875) -> S=16379, data_o=16'h3F7F (truncate build); 16'h3F80 with LOG_ROUND_EN.
// - Specials: 16'h0000 and 16'h8000 -> 16'hFF80; 16'hBF80 -> 16'h7FC0; 16'h7FC1 -> 16'h7FC0; 16'h7F80 -> 16'h7F80.
// - Back-to-back stream of 8 operands with ready_i toggled randomly -> results in order, tags match, no drop or duplicate, data_o stable while stalled.
// - Assert rst with 3 operands in flight -> next cycle valid_o=0, data_o=0; first post-reset operand emerges after exactly 3 cycles.

Source files
------------

// File: rtl/log_bf16.sv
// Pipelined bfloat16 natural log: data_o = ln(data_i), 3 stages, valid/ready with sideband tag.
// Define LOG_ROUND_EN to round-to-nearest-even in the final stage instead of truncating.
module log_bf16 #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [15:0]      data_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [15:0]      data_o,
  output logic [TAG_W-1:0] tag_o
);

  // Piecewise-linear ln(1.m) breakpoints, Q0.14.
  function automatic logic [13:0] seg_t(input logic [3:0] k);
    unique case (k)
      4'd0:    seg_t = 14'd0;
      4'd1:    seg_t = 14'd1930;
      4'd2:    seg_t = 14'd3656;
      4'd3:    seg_t = 14'd5218;
      4'd4:    seg_t = 14'd6643;
      4'd5:    seg_t = 14'd7955;
      4'd6:    seg_t = 14'd9169;
      4'd7:    seg_t = 14'd10299;
      4'd8:    seg_t = 14'd11357;
      default: seg_t = 14'd0;
    endcase
  endfunction

  logic             adv;
  logic             v1_q, v1_d, sp1_q, sp1_d;
  logic [15:0]      spv1_q, spv1_d;
  logic [7:0]       e1_q, e1_d;
  logic [13:0]      frac1_q, frac1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic             v2_q, v2_d, sp2_q, sp2_d;
  logic [15:0]      spv2_q, spv2_d;
  logic [23:0]      s2_q, s2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [3:0]  k_lo, k_hi;
  logic [13:0] t_lo, t_hi, t_diff;
  logic [17:0] interp;
  logic [9:0]  ediff;
  logic [23:0] mag;
  logic [4:0]  lead;
  logic [20:0] norm;
  logic [6:0]  mant;
  logic [7:0]  expo;
  logic        unused_bits;

  assign adv     = ~valid_q | ready_i;
  assign ready_o = adv;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

  // S1: classify specials and interpolate the mantissa segment.
  always_comb begin
    v1_d    = valid_i;
    tag1_d  = tag_i;
    e1_d    = data_i[14:7];
    k_lo    = {1'b0, data_i[6:4]};
    k_hi    = k_lo + 4'd1;
    t_lo    = seg_t(k_lo);
    t_hi    = seg_t(k_hi);
    t_diff  = t_hi - t_lo;
    interp  = 18'(t_diff) * 18'(data_i[3:0]);
    frac1_d = t_lo + 14'(interp >> 4);
    sp1_d   = 1'b0;
    spv1_d  = 16'h0000;
    if (data_i[14:7] == 8'd0) begin
      sp1_d  = 1'b1;
      spv1_d = 16'hFF80;
    end else if (data_i[15] || (data_i[14:7] == 8'hFF && data_i[6:0] != 7'd0)) begin
      sp1_d  = 1'b1;
      spv1_d = 16'h7FC0;
    end else if (data_i[14:7] == 8'hFF) begin
      sp1_d  = 1'b1;
      spv1_d = 16'h7F80;
    end
  end

  // S2: S = (e-127)*ln2 + frac in Q9.14; product low bits are sign-agnostic.
  always_comb begin
    v2_d   = v1_q;
    sp2_d  = sp1_q;
    spv2_d = spv1_q;
    tag2_d = tag1_q;
    ediff  = {2'b00, e1_q} - 10'd127;
    s2_d   = ({{14{ediff[9]}}, ediff} * 24'd11357) + {10'd0, frac1_q};
  end

  // S3: fixed-point to bf16 via leading-one normalisation.
  always_comb begin
    valid_d = v2_q;
    tag_d   = tag2_q;
    mag     = s2_q[23] ? -s2_q : s2_q;
    lead    = 5'd0;
    for (int i = 0; i < 21; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    norm = mag[20:0] << (5'd20 - lead);
    mant = norm[19:13];
    expo = {3'b000, lead} + 8'd113;
`ifdef LOG_ROUND_EN
    if (norm[12] && ((|norm[11:0]) || mant[0])) begin
      if (mant == 7'h7F) begin
        mant = 7'd0;
        expo = expo + 8'd1;
      end else begin
        mant = mant + 7'd1;
      end
    end
`else
`endif
    if (sp2_q)             data_d = spv2_q;
    else if (s2_q == 24'd0) data_d = 16'h0000;
    else                   data_d = {s2_q[23], expo, mant};
  end

  assign unused_bits = ^{norm[20], norm[12:0], mag[23:21]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sp1_q   <= 1'b0;
      spv1_q  <= 16'h0000;
      e1_q    <= 8'd0;
      frac1_q <= 14'd0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      sp2_q   <= 1'b0;
      spv2_q  <= 16'h0000;
      s2_q    <= 24'd0;
      tag2_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
      tag_q   <= '0;
    end else if (adv) begin
      v1_q    <= v1_d;
      sp1_q   <= sp1_d;
      spv1_q  <= spv1_d;
      e1_q    <= e1_d;
      frac1_q <= frac1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      sp2_q   <= sp2_d;
      spv2_q  <= spv2_d;
      s2_q    <= s2_d;
      tag2_q  <= tag2_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_log_bf16.sv
// Self-checking bench for log_bf16: reference model + scoreboard, directed vectors, stalls, reset.
module tb_log_bf16;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_o, valid_o, ready_i;
  logic [15:0] data_i, data_o;
  logic [3:0]  tag_i, tag_o;

  int   checks = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;
  logic [19:0] exp_q[$];
  bit          held = 1'b0;
  logic [15:0] held_data;
  logic [3:0]  held_tag;
  int   tab [0:8] = '{0, 1930, 3656, 5218, 6643, 7955, 9169, 10299, 11357};

  log_bf16 #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ln(x) from the arithmetic definition, using plain integers.
  function automatic logic [15:0] model(input logic [15:0] x);
    int e, m, k, f, frac, s_val, a, p, ex, mant, sh, rem, half;
    bit neg;
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    if (e == 0) return 16'hFF80;
    if (x[15] || (e == 255 && m != 0)) return 16'h7FC0;
    if (e == 255) return 16'h7F80;
    k = m / 16;
    f = m % 16;
    frac = tab[k] + ((tab[k+1] - tab[k]) * f) / 16;
    s_val = (e - 127) * 11357 + frac;
    if (s_val == 0) return 16'h0000;
    neg = s_val < 0;
    a = neg ? -s_val : s_val;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    ex = p + 113;
    if (p >= 7) begin
      sh = p - 7;
      mant = (a >> sh) % 128;
`ifdef LOG_ROUND_EN
      if (sh > 0) begin
        rem = a % (1 << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
        if (mant == 128) begin
          mant = 0;
          ex++;
        end
      end
`endif
    end else begin
      mant = (a << (7 - p)) % 128;
    end
    return {neg, 8'(ex), 7'(mant)};
  endfunction

  always @(posedge clk) begin
    #1;
    ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and hold-stability checker, sampled mid-cycle.
  always @(negedge clk) begin
    logic [19:0] ent;
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (valid_i && ready_o) exp_q.push_back({tag_i, model(data_i)});
      if (held) begin
        chk("hold_valid", 32'(valid_o), 32'd1);
        chk("hold_data", 32'(data_o), 32'(held_data));
        chk("hold_tag", 32'(tag_o), 32'(held_tag));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(data_o), 32'hFFFFFFFF);
        end else begin
          ent = exp_q.pop_front();
          chk("out_data", 32'(data_o), 32'(ent[15:0]));
          chk("out_tag", 32'(tag_o), 32'(ent[19:16]));
        end
      end
      held      = valid_o && !ready_i;
      held_data = data_o;
      held_tag  = tag_o;
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] t);
    bit acc;
    int n;
    valid_i = 1'b1;
    data_i  = d;
    tag_i   = t;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'(n), 32'd0);
    valid_i = 1'b0;
  endtask

  task automatic latency(input logic [15:0] d, input logic [3:0] t, input logic [15:0] req);
    int cnt;
    valid_i = 1'b1;
    data_i  = d;
    tag_i   = t;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) valid_i = 1'b0;
      if (valid_o) break;
    end
    chk("latency", 32'(cnt), 32'd3);
    chk("lat_data", 32'(data_o), 32'(req));
    chk("lat_tag", 32'(tag_o), 32'(t));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [15:0] vecs [0:13] = '{16'h4000, 16'h3F00, 16'h402E, 16'h0000, 16'h8000, 16'hBF80,
                               16'h7FC1, 16'h7F80, 16'h4120, 16'h3DCC, 16'h7F7F, 16'h0080,
                               16'h3F81, 16'h40C9};

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    data_i = 16'h0;
    tag_i = 4'h0;
    ready_i = 1'b1;

    // Model pinned against hand-computed results.
    chk("model_1p0", 32'(model(16'h3F80)), 32'h0000);
    chk("model_2p0", 32'(model(16'h4000)), 32'h3F31);
    chk("model_0p5", 32'(model(16'h3F00)), 32'hBF31);
`ifdef LOG_ROUND_EN
    chk("model_e", 32'(model(16'h402E)), 32'h3F80);
`else
    chk("model_e", 32'(model(16'h402E)), 32'h3F7F);
`endif
    chk("model_zero", 32'(model(16'h0000)), 32'hFF80);
    chk("model_negzero", 32'(model(16'h8000)), 32'hFF80);
    chk("model_neg1", 32'(model(16'hBF80)), 32'h7FC0);
    chk("model_nan", 32'(model(16'h7FC1)), 32'h7FC0);
    chk("model_inf", 32'(model(16'h7F80)), 32'h7F80);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    rst = 1'b0;

    latency(16'h3F80, 4'd3, 16'h0000);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) send(vecs[i], 4'(i));
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(vecs[(i * 5) % 14], 4'(15 - i));
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;

    send(16'h4000, 4'd1);
    send(16'h3F00, 4'd2);
    send(16'h402E, 4'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_data", 32'(data_o), 32'd0);
    rst = 1'b0;
    latency(16'h4000, 4'd5, 16'h3F31);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
